// File: rtl/data_mem_access_ctrl_pkg.sv
// data_mem_access_ctrl_pkg: access sizes, FSM encodings and shared helpers.
// Revision 1.0
`default_nettype none

package data_mem_access_ctrl_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_STORE  = 3'd2;
   localparam logic [2:0] ST_RMW_RD = 3'd3;
   localparam logic [2:0] ST_RMW_WR = 3'd4;
   localparam logic [2:0] ST_RESP   = 3'd5;

   localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

   // Size code 11 is an alias for a word access.
   function automatic logic is_word(input logic [1:0] size);
      return (size == SIZE_WORD) || (size == 2'b11);
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      if (is_word(size))
         return addr_lo != 2'b00;
      else if (size == SIZE_HALF)
         return addr_lo[0];
      else
         return 1'b0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_access_ctrl_if.sv
// data_mem_access_ctrl_if: CPU request/response channel plus data_mem bus.
// Revision 1.0
`default_nettype none

interface data_mem_access_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        mem_read;
   logic        mem_write;

   // master: the environment (CPU datapath and memory); slave: the controller
   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, read_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             address, write_data, mem_read, mem_write
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, read_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
             address, write_data, mem_read, mem_write
   );

endinterface

`default_nettype wire

// File: rtl/data_mem_access_ctrl_mem_data_align.sv
// mem_data_align: big-endian load extraction/extension and sub-word store merge.
// Revision 1.0
`default_nettype none

module mem_data_align
   import data_mem_access_ctrl_pkg::*;
(
   input  wire logic [1:0]  i_size,
   input  wire logic        i_signed,
   input  wire logic [31:0] i_rdata,
   input  wire logic [31:0] i_wdata,
   output logic      [31:0] o_load_data,
   output logic      [31:0] o_merged
);

   // The addressed byte/half always sits in the top of the returned word.
   always_comb begin
      o_load_data = i_rdata;
      o_merged    = i_wdata;
      if (i_size == SIZE_BYTE) begin
         o_load_data = {{24{i_signed & i_rdata[31]}}, i_rdata[31:24]};
         o_merged    = {i_wdata[7:0], i_rdata[23:0]};
      end else if (i_size == SIZE_HALF) begin
         o_load_data = {{16{i_signed & i_rdata[31]}}, i_rdata[31:16]};
         o_merged    = {i_wdata[15:0], i_rdata[15:0]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/data_mem_access_ctrl.sv
// data_mem_access_ctrl: load/store controller for big-endian data_mem; optional MEM_ALIGN_CHECK_EN.
// Revision 1.0
`default_nettype none

module data_mem_access_ctrl
   import data_mem_access_ctrl_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             rst,
   data_mem_access_ctrl_if.slave bus
);

   logic [2:0]  state_q,  state_d;
   logic [31:0] addr_q,   addr_d;
   logic [31:0] wdata_q,  wdata_d;
   logic [31:0] merged_q, merged_d;
   logic [31:0] rdata_q,  rdata_d;
   logic [1:0]  size_q,   size_d;
   logic        sext_q,   sext_d;
   logic        err_q,    err_d;

   logic        w_misaligned;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misaligned = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
   assign w_misaligned = 1'b0;
`endif

   mem_data_align u_align (
      .i_size      (size_q),
      .i_signed    (sext_q),
      .i_rdata     (bus.read_data),
      .i_wdata     (wdata_q),
      .o_load_data (w_load_data),
      .o_merged    (w_merged)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      merged_d = merged_q;
      rdata_d  = rdata_q;
      size_d   = size_q;
      sext_d   = sext_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               size_d  = bus.req_size;
               sext_d  = bus.req_signed;
               rdata_d = WORD_ZERO;
               err_d   = w_misaligned;
               if (w_misaligned)
                  state_d = ST_RESP;
               else if (!bus.req_write)
                  state_d = ST_LOAD;
               else if (is_word(bus.req_size))
                  state_d = ST_STORE;
               else
                  state_d = ST_RMW_RD;
            end
         end
         ST_LOAD: begin
            rdata_d = w_load_data;
            state_d = ST_RESP;
         end
         ST_STORE:  state_d = ST_RESP;
         ST_RMW_RD: begin
            merged_d = w_merged;
            state_d  = ST_RMW_WR;
         end
         ST_RMW_WR: state_d = ST_RESP;
         ST_RESP: begin
            // Response fields are only meaningful during the pulse.
            rdata_d = WORD_ZERO;
            err_d   = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= WORD_ZERO;
         wdata_q  <= WORD_ZERO;
         merged_q <= WORD_ZERO;
         rdata_q  <= WORD_ZERO;
         size_q   <= SIZE_BYTE;
         sext_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         merged_q <= merged_d;
         rdata_q  <= rdata_d;
         size_q   <= size_d;
         sext_q   <= sext_d;
         err_q    <= err_d;
      end
   end

   // Memory strobes come straight from the current state so an in-flight write
   // still lands on the edge where reset is sampled.
   always_comb begin
      bus.address    = WORD_ZERO;
      bus.write_data = WORD_ZERO;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      case (state_q)
         ST_LOAD, ST_RMW_RD: begin
            bus.mem_read = 1'b1;
            bus.address  = addr_q;
         end
         ST_STORE: begin
            bus.mem_write  = 1'b1;
            bus.address    = addr_q;
            bus.write_data = wdata_q;
         end
         ST_RMW_WR: begin
            bus.mem_write  = 1'b1;
            bus.address    = addr_q;
            bus.write_data = merged_q;
         end
         default: ;
      endcase
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

endmodule

`default_nettype wire

// File: doc/data_mem_access_ctrl.md
# data_mem_access_ctrl

Initiator-side controller for the single-port, byte-addressed, big-endian `data_mem`. It accepts load/store requests from the CPU datapath and drives the memory's `address`, `write_data`, `mem_read` and `mem_write` lines. Sub-word stores are converted into read-modify-write sequences. Load results are sign- or zero-extended before being returned with a one-cycle response pulse.

## Interface
- No parameters. Widths are fixed: 32-bit address and 32-bit data.
- `clk` in 1: single clock. Memory writes occur on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller is idle and can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: `SIZE_BYTE`=00, `SIZE_HALF`=01, `SIZE_WORD`=10. Code 11 is treated as word.
- `req_signed` in 1: sign-extend load data.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data. 0 for stores.
- `resp_err` out 1: misaligned access, valid with `resp_valid`.
- `address` out 32: to memory.
- `write_data` out 32: to memory.
- `read_data` in 32: from memory. Combinational while `mem_read`=1, Z otherwise.
- `mem_read` out 1: to memory.
- `mem_write` out 1: to memory.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch addr, wdata, size, signed and write.
  - Next state: misaligned (with check enabled) → RESP with err. Load → LOAD. Word store → STORE. Byte/half store → RMW_RD.
- LOAD:
  - Drive `mem_read`=1 and `address`=latched addr.
  - Register the extended `read_data` at the clock edge.
  - Next state: RESP.
- STORE:
  - Drive `mem_write`=1, `address`, and `write_data`=latched wdata.
  - Next state: RESP.
- RMW_RD:
  - Drive `mem_read`=1.
  - Register the merged word: the byte replaces bits [31:24]; the half replaces bits [31:16].
  - Next state: RMW_WR.
- RMW_WR:
  - Drive `mem_write`=1 with the merged word.
  - Next state: RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle.
  - Next state: IDLE. The requester must accept the response; there is no backpressure.
- Big-endian extraction: the byte at addr is `read_data[31:24]`; the half at addr is `read_data[31:16]`.
  - Signed: replicate the top bit.
  - Unsigned: zero-fill.
- Memory outputs are decoded combinationally from state.
  - Outside LOAD, STORE, RMW_RD and RMW_WR, `address`, `write_data`, `mem_read` and `mem_write` are all 0.
  - `mem_read` and `mem_write` are never both 1.
- Addresses are passed unmodified. The memory uses `address[15:0]` and wraps at 0xFFFF.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready`=1.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - All memory outputs = 0.
- Accept edge is k. `resp_valid` is high in:
  - cycle k+2 for a load or word store;
  - cycle k+3 for a sub-word store;
  - cycle k+1 for an error.
- `req_ready`=0 from k+1 until the cycle after RESP, so there is one request in flight at most.
- The response is registered and held stable only during the RESP cycle.
- Reset mid-operation:
  - The next state is IDLE and no response is produced.
  - If `rst` rises while the state is STORE or RMW_WR, the write at that same edge still completes, because `mem_write` is combinational from the current state.
  - If reset hits during RMW_RD, no write occurs.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A half with `addr[0]`=1 is misaligned.
  - A word with `addr[1:0]`≠0 is misaligned.
  - A misaligned request goes to RESP with `resp_err`=1 and `resp_rdata`=0. No memory access is made.
- `MEM_ALIGN_CHECK_EN` undefined:
  - Unaligned accesses are performed as issued; the memory handles any byte address.
  - `resp_err` is tied to 0.

## Structure
- Add to `constant_values.vh`:
  - `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`;
  - the six state encodings;
  - the existing `WORD_ZERO` constant is used for idle outputs.
- One combinational sub-module, `mem_data_align`:
  - performs load extraction and extension;
  - performs store merge;
  - inputs: size, signed, read word, store data.

## Test plan
- Word store of 0x11223344 at 8, then word load at 8:
  - the memory's write display fires once;
  - `resp_rdata`=0x11223344 at k+2.
- With 0x11223344 at 8:
  - signed byte load at 11 → 0x00000044;
  - unsigned half load at 8 → 0x00001122.
- Word 0x88990000 at 16, signed half load at 16 → 0xFFFF8899. The same load unsigned → 0x00008899.
- Byte store 0xAB at 9 over 0x11223344 at 8:
  - RMW_RD then RMW_WR occur;
  - `resp_valid` at k+3;
  - a word load at 8 returns 0x11AB3344.
- With `MEM_ALIGN_CHECK_EN`, word load at 6:
  - `resp_err`=1 at k+1;
  - `mem_read` stays 0.
- Without the macro, the same load returns the bytes at 6..9.
- Assert `rst` during RMW_RD of a byte store at 8:
  - no `mem_write` pulse;
  - `req_ready`=1 on the next cycle;
  - memory word at 8 is unchanged.
